snake_move_sched: RTL and testbench

//  Schedules snake movement steps while game_status == PLAY (2'b10).

---
 rtl/snake_move_sched.sv | 127 ++++++++++++
 tb/tb_snake_move_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_move_sched.sv
// Snake step scheduler: holds committed/requested heading, times move steps from a
// speed-dependent period, and hands each move to the datapath over a req/ack handshake.
module snake_move_sched #(
  parameter int unsigned BASE_PERIOD = 25_000_000,
  parameter int unsigned STEP_DEC    = 1_500_000,
  parameter int unsigned MIN_PERIOD  = 5_000_000,
  parameter int unsigned MAX_LEVEL   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] game_status,
  input  logic       key1_press,
  input  logic       key2_press,
  input  logic       key3_press,
  input  logic       key4_press,
  input  logic       eat_food,
  input  logic       move_ack,
  output logic [1:0] direction,
  output logic       move_req,
  output logic       grow,
  output logic [3:0] speed_level
);

  localparam logic [1:0] GS_RESTART = 2'b00;
  localparam logic [1:0] GS_PLAY    = 2'b10;
  localparam logic [1:0] DIR_UP     = 2'b00;
  localparam logic [1:0] DIR_DOWN   = 2'b01;
  localparam logic [1:0] DIR_LEFT   = 2'b10;
  localparam logic [1:0] DIR_RIGHT  = 2'b11;
  localparam logic [3:0] LVL_MAX    = 4'(MAX_LEVEL);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_REQ} state_t;

  state_t      r_state;
  logic [1:0]  r_next_dir;
  logic        r_grow_pend;
  logic [31:0] r_cnt;
  logic [31:0] r_period;

  logic [31:0] w_dec;
  logic [31:0] w_period;
  logic        w_key_vld;
  logic [1:0]  w_key_dir;
  logic        w_key_ok;
  logic [3:0]  w_level_inc;

  // Clamp before subtracting so a large level never wraps the period.
  assign w_dec    = 32'(speed_level) * STEP_DEC;
  assign w_period = (w_dec >= (BASE_PERIOD - MIN_PERIOD)) ? MIN_PERIOD : (BASE_PERIOD - w_dec);

  always_comb begin
    w_key_vld = 1'b1;
    w_key_dir = DIR_RIGHT;
    if (key1_press)      w_key_dir = DIR_UP;
    else if (key2_press) w_key_dir = DIR_DOWN;
    else if (key3_press) w_key_dir = DIR_LEFT;
    else if (key4_press) w_key_dir = DIR_RIGHT;
    else                 w_key_vld = 1'b0;
  end

  // Opposite headings share bit 1 and differ only in bit 0.
  assign w_key_ok    = w_key_vld && ((w_key_dir ^ direction) != 2'b01);
  assign w_level_inc = (speed_level == LVL_MAX) ? speed_level : speed_level + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_next_dir  <= DIR_RIGHT;
      r_grow_pend <= 1'b0;
      r_cnt       <= '0;
      r_period    <= BASE_PERIOD;
      direction   <= DIR_RIGHT;
      move_req    <= 1'b0;
      grow        <= 1'b0;
      speed_level <= '0;
    end else begin
      if (w_key_ok) r_next_dir <= w_key_dir;
      if (eat_food) begin
        r_grow_pend <= 1'b1;
        speed_level <= w_level_inc;
      end
      if (game_status != GS_PLAY) begin
        r_state     <= S_IDLE;
        r_cnt       <= '0;
        move_req    <= 1'b0;
        grow        <= 1'b0;
        r_grow_pend <= 1'b0;
        if (game_status == GS_RESTART) begin
          direction   <= DIR_RIGHT;
          r_next_dir  <= DIR_RIGHT;
          speed_level <= '0;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state  <= S_COUNT;
            r_cnt    <= '0;
            r_period <= w_period;
          end
          S_COUNT: begin
            if (r_cnt == r_period - 32'd1) begin
              r_cnt     <= '0;
              direction <= r_next_dir;
              move_req  <= 1'b1;
              grow      <= r_grow_pend;
              r_state   <= S_REQ;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          S_REQ: begin
            // Period is latched here so level changes apply from the next full step.
            if (move_ack) begin
              move_req <= 1'b0;
              grow     <= 1'b0;
              if (!eat_food) r_grow_pend <= 1'b0;
              r_period <= w_period;
              r_state  <= S_COUNT;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snake_move_sched.sv
// Directed bench for snake_move_sched with a short step period (10/2/4/15).
module tb_snake_move_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] game_status = 2'b00;
  logic       key1_press = 1'b0, key2_press = 1'b0, key3_press = 1'b0, key4_press = 1'b0;
  logic       eat_food = 1'b0;
  logic       move_ack = 1'b0;
  logic [1:0] direction;
  logic       move_req;
  logic       grow;
  logic [3:0] speed_level;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] RESTART = 2'b00, START = 2'b01, PLAY = 2'b10, DIE = 2'b11;

  snake_move_sched #(
    .BASE_PERIOD(10), .STEP_DEC(2), .MIN_PERIOD(4), .MAX_LEVEL(15)
  ) dut (
    .clk(clk), .rst(rst), .game_status(game_status),
    .key1_press(key1_press), .key2_press(key2_press),
    .key3_press(key3_press), .key4_press(key4_press),
    .eat_food(eat_food), .move_ack(move_ack),
    .direction(direction), .move_req(move_req), .grow(grow), .speed_level(speed_level)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (move_req !== 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    if (move_req !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_req: move_req=%b after %0d cycles, required 1", move_req, n);
    end
  endtask

  task automatic pulse_keys(input logic [3:0] k);
    {key4_press, key3_press, key2_press, key1_press} = k;
    step(1);
    {key4_press, key3_press, key2_press, key1_press} = 4'b0000;
  endtask

  task automatic pulse_eat(input int n);
    repeat (n) begin
      eat_food = 1'b1;
      step(1);
      eat_food = 1'b0;
    end
  endtask

  task automatic ack_now();
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    game_status = PLAY;
    step(2);
    checks++; if (direction !== 2'b11) begin errors++; $display("FAIL reset_dir: got %b want 11", direction); end
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", move_req); end
    checks++; if (grow !== 1'b0) begin errors++; $display("FAIL reset_grow: got %b want 0", grow); end
    checks++; if (speed_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", speed_level); end
    game_status = RESTART;
    step(1);
    rst = 1'b1;
    step(1);
  endtask

  task automatic test_period();
    int n;
    game_status = PLAY;
    wait_req(n);
    checks++; if (n != 11) begin errors++; $display("FAIL first_req_latency: got %0d want 11", n); end
    step(1);
    checks++; if (move_req !== 1'b1) begin errors++; $display("FAIL req_held: got %b want 1", move_req); end
    ack_now();
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL req_drop_on_ack: got %b want 0", move_req); end
    wait_req(n);
    checks++; if (n + 2 != 12) begin errors++; $display("FAIL req_spacing: got %0d want 12", n + 2); end
    checks++; if (direction !== 2'b11) begin errors++; $display("FAIL dir_steady: got %b want 11", direction); end
    // ack left high through COUNT and the rising edge must not short-circuit REQ
    move_ack = 1'b1;
    step(1);
    wait_req(n);
    checks++; if (n != 10) begin errors++; $display("FAIL ack_ignored_in_count: got %0d want 10", n); end
    step(1);
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL ack_in_req: got %b want 0", move_req); end
    move_ack = 1'b0;
  endtask

  task automatic test_keys();
    int n;
    pulse_keys(4'b0100);
    pulse_keys(4'b0001);
    checks++; if (direction !== 2'b11) begin errors++; $display("FAIL dir_before_commit: got %b want 11", direction); end
    wait_req(n);
    checks++; if (direction !== 2'b00) begin errors++; $display("FAIL dir_up_commit: got %b want 00", direction); end
    ack_now();
    pulse_keys(4'b0100);
    wait_req(n);
    checks++; if (direction !== 2'b10) begin errors++; $display("FAIL dir_left_commit: got %b want 10", direction); end
    ack_now();
    pulse_keys(4'b1001);
    wait_req(n);
    checks++; if (direction !== 2'b00) begin errors++; $display("FAIL key_priority: got %b want 00", direction); end
    ack_now();
  endtask

  task automatic test_grow();
    int n;
    pulse_eat(1);
    wait_req(n);
    checks++; if (grow !== 1'b1) begin errors++; $display("FAIL grow_set: got %b want 1", grow); end
    checks++; if (speed_level !== 4'd1) begin errors++; $display("FAIL level_one: got %0d want 1", speed_level); end
    ack_now();
    checks++; if (grow !== 1'b0) begin errors++; $display("FAIL grow_drop_on_ack: got %b want 0", grow); end
    wait_req(n);
    checks++; if (n != 8) begin errors++; $display("FAIL period_level1: got %0d want 8", n); end
    checks++; if (grow !== 1'b0) begin errors++; $display("FAIL grow_next_move: got %b want 0", grow); end
  endtask

  task automatic test_speed();
    int n;
    pulse_eat(3);
    checks++; if (speed_level !== 4'd4) begin errors++; $display("FAIL level_four: got %0d want 4", speed_level); end
    ack_now();
    wait_req(n);
    checks++; if (n != 4) begin errors++; $display("FAIL period_clamp_l4: got %0d want 4", n); end
    pulse_eat(8);
    checks++; if (speed_level !== 4'd12) begin errors++; $display("FAIL level_twelve: got %0d want 12", speed_level); end
    ack_now();
    wait_req(n);
    checks++; if (n != 4) begin errors++; $display("FAIL period_clamp_l12: got %0d want 4", n); end
    pulse_eat(5);
    checks++; if (speed_level !== 4'd15) begin errors++; $display("FAIL level_saturate: got %0d want 15", speed_level); end
  endtask

  task automatic test_stall();
    move_ack = 1'b0;
    step(50);
    checks++; if (move_req !== 1'b1) begin errors++; $display("FAIL req_stall: got %b want 1", move_req); end
    game_status = DIE;
    step(1);
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL die_drops_req: got %b want 0", move_req); end
    checks++; if (direction !== 2'b00) begin errors++; $display("FAIL die_keeps_dir: got %b want 00", direction); end
    checks++; if (speed_level !== 4'd15) begin errors++; $display("FAIL die_keeps_level: got %0d want 15", speed_level); end
    step(20);
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL die_idle: got %b want 0", move_req); end
  endtask

  task automatic test_restart();
    int n;
    game_status = RESTART;
    step(1);
    checks++; if (speed_level !== 4'd0) begin errors++; $display("FAIL restart_level: got %0d want 0", speed_level); end
    checks++; if (direction !== 2'b11) begin errors++; $display("FAIL restart_dir: got %b want 11", direction); end
    game_status = START;
    pulse_keys(4'b0001);
    game_status = PLAY;
    wait_req(n);
    checks++; if (n != 11) begin errors++; $display("FAIL restart_latency: got %0d want 11", n); end
    checks++; if (direction !== 2'b00) begin errors++; $display("FAIL key_in_start: got %b want 00", direction); end
  endtask

  task automatic test_reset_mid_req();
    int n;
    pulse_eat(2);
    checks++; if (move_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req: got %b want 1", move_req); end
    rst = 1'b0;
    step(1);
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", move_req); end
    checks++; if (direction !== 2'b11) begin errors++; $display("FAIL rst_dir: got %b want 11", direction); end
    checks++; if (speed_level !== 4'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", speed_level); end
    checks++; if (grow !== 1'b0) begin errors++; $display("FAIL rst_grow: got %b want 0", grow); end
    rst = 1'b1;
    wait_req(n);
    checks++; if (n != 11) begin errors++; $display("FAIL post_rst_latency: got %0d want 11", n); end
    checks++; if (grow !== 1'b0) begin errors++; $display("FAIL post_rst_grow: got %b want 0", grow); end
  endtask

  initial begin
    test_reset();
    test_period();
    test_keys();
    test_grow();
    test_speed();
    test_stall();
    test_restart();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
